// File: rtl/json_feedback_receiver_pkg.sv
`default_nettype none
// ============================================================================
// Module : json_feedback_receiver_pkg
// Purpose: Shared definitions for the JSON feedback receiver: ASCII codes the
//          parser reacts to, the parser state encoding and the default baud
//          divider.
// Ports  : none (package)
// Rev    : 1.0  initial release
// ============================================================================
package json_feedback_receiver_pkg;

  // 50 MHz / 115200 baud
  localparam int DEFAULT_CLKS_PER_BIT = 434;

  localparam logic [7:0] ASCII_LBRACE = 8'h7B;  // '{'
  localparam logic [7:0] ASCII_RBRACE = 8'h7D;  // '}'
  localparam logic [7:0] ASCII_QUOTE  = 8'h22;  // '"'
  localparam logic [7:0] ASCII_COLON  = 8'h3A;  // ':'
  localparam logic [7:0] ASCII_COMMA  = 8'h2C;  // ','
  localparam logic [7:0] ASCII_T      = 8'h54;  // 'T'
  localparam logic [7:0] ASCII_SPACE  = 8'h20;  // ' '
  localparam logic [7:0] ASCII_ZERO   = 8'h30;  // '0'
  localparam logic [7:0] ASCII_NINE   = 8'h39;  // '9'

  typedef enum logic [1:0] {
    PS_IDLE = 2'd0,
    PS_KEY  = 2'd1,
    PS_NUM  = 2'd2,
    PS_SKIP = 2'd3
  } parser_state_t;

  // Character expected at each position of the key sequence "T":
  function automatic logic [7:0] key_char(input logic [1:0] idx);
    logic [7:0] c;
    case (idx)
      2'd0:    c = ASCII_QUOTE;
      2'd1:    c = ASCII_T;
      2'd2:    c = ASCII_QUOTE;
      default: c = ASCII_COLON;
    endcase
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/json_feedback_receiver_if.sv
`default_nettype none
// ============================================================================
// Module : json_feedback_receiver_if
// Purpose: Bundles the serial input and the decoded-message outputs of the
//          JSON feedback receiver.
// Ports  : uart_in      serial line into the receiver (idle high)
//          msg_type     last decoded "T" value
//          msg_valid    one-cycle pulse when msg_type is updated
//          frame_error  one-cycle pulse on a malformed/aborted frame
//          rx_byte      last received character (debug)
//          master modport drives the line, slave modport is the receiver.
// Rev    : 1.0  initial release
// ============================================================================
interface json_feedback_receiver_if #(
  parameter int BITS_N = 8
);
  logic              uart_in;
  logic [15:0]       msg_type;
  logic              msg_valid;
  logic              frame_error;
  logic [BITS_N-1:0] rx_byte;

  modport master (
    output uart_in,
    input  msg_type,
    input  msg_valid,
    input  frame_error,
    input  rx_byte
  );

  modport slave (
    input  uart_in,
    output msg_type,
    output msg_valid,
    output frame_error,
    output rx_byte
  );
endinterface
`default_nettype wire

// File: rtl/json_feedback_receiver_uart_rx.sv
`default_nettype none
// ============================================================================
// Module : uart_rx
// Purpose: 8N1-style UART character receiver with a 2-flop input
//          synchronizer, mid-bit sampling and stop-bit checking.
// Ports  : clk          system clock
//          rst          synchronous active-high reset
//          rx_in        asynchronous serial line, idle high, LSB first
//          data         received character, valid with byte_valid
//          byte_valid   one-cycle pulse, one cycle after a good stop sample
//          framing_err  one-cycle pulse when the stop bit samples low
// Rev    : 1.0  initial release
// ============================================================================
module uart_rx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int BITS_N       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_in,
  output logic [BITS_N-1:0] data,
  output logic              byte_valid,
  output logic              framing_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam int BIT_W = $clog2(BITS_N + 1);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(BITS_N - 1);

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  logic              sync1_q, sync2_q, prev_q;
  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [BITS_N-1:0] shift_q, shift_d;
  logic [BITS_N-1:0] data_q, data_d;
  logic              byte_valid_q, byte_valid_d;
  logic              framing_err_q, framing_err_d;

  // A real high-to-low transition is required; a line that stays low after
  // a bad stop bit must not be mistaken for a new start bit.
  logic fall_edge;
  logic half_tick;
  logic full_tick;
  assign fall_edge = prev_q & ~sync2_q;
  assign half_tick = (cnt_q == HALF_M1);
  assign full_tick = (cnt_q == FULL_M1);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q       <= 1'b1;
      sync2_q       <= 1'b1;
      prev_q        <= 1'b1;
      state_q       <= RX_IDLE;
      cnt_q         <= '0;
      bit_q         <= '0;
      shift_q       <= '0;
      data_q        <= '0;
      byte_valid_q  <= 1'b0;
      framing_err_q <= 1'b0;
    end else begin
      sync1_q       <= rx_in;
      sync2_q       <= sync1_q;
      prev_q        <= sync2_q;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bit_q         <= bit_d;
      shift_q       <= shift_d;
      data_q        <= data_d;
      byte_valid_q  <= byte_valid_d;
      framing_err_q <= framing_err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      RX_IDLE:  if (fall_edge) state_d = RX_START;
      // High at mid-start means a glitch: abandon without a byte.
      RX_START: if (half_tick) state_d = sync2_q ? RX_IDLE : RX_DATA;
      RX_DATA:  if (full_tick && (bit_q == LAST_BIT)) state_d = RX_STOP;
      RX_STOP:  if (full_tick) state_d = RX_IDLE;
      default:  state_d = RX_IDLE;
    endcase
  end

  // Datapath / output logic
  always_comb begin
    cnt_d         = cnt_q + CNT_W'(1);
    bit_d         = bit_q;
    shift_d       = shift_q;
    data_d        = data_q;
    byte_valid_d  = 1'b0;
    framing_err_d = 1'b0;
    case (state_q)
      RX_IDLE: cnt_d = '0;
      RX_START: begin
        if (half_tick) begin
          cnt_d = '0;
          bit_d = '0;
        end
      end
      RX_DATA: begin
        if (full_tick) begin
          cnt_d   = '0;
          shift_d = BITS_N'({sync2_q, shift_q} >> 1);
          bit_d   = bit_q + BIT_W'(1);
        end
      end
      RX_STOP: begin
        if (full_tick) begin
          cnt_d = '0;
          if (sync2_q) begin
            data_d       = shift_q;
            byte_valid_d = 1'b1;
          end else begin
            framing_err_d = 1'b1;
          end
        end
      end
      default: cnt_d = '0;
    endcase
  end

  assign data        = data_q;
  assign byte_valid  = byte_valid_q;
  assign framing_err = framing_err_q;

endmodule
`default_nettype wire

// File: rtl/json_feedback_receiver.sv
`default_nettype none
// ============================================================================
// Module : json_feedback_receiver
// Purpose: Receives UART characters and parses frames of the form
//          {"T":<uint16>, ...} reporting the "T" value.
// Ports  : clk   system clock (rising edge)
//          rst   synchronous active-high reset
//          bus   slave side of json_feedback_receiver_if
//                (uart_in in; msg_type, msg_valid, frame_error, rx_byte out)
// Rev    : 1.0  initial release
// ============================================================================
module json_feedback_receiver
  import json_feedback_receiver_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int BITS_N       = 8,
  parameter int MAX_BYTES    = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  json_feedback_receiver_if.slave  bus
);

  localparam int LEN_W = $clog2(MAX_BYTES + 1);
  localparam logic [LEN_W-1:0] LEN_LIMIT = LEN_W'(MAX_BYTES);

  logic [BITS_N-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ferr;

  uart_rx #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .BITS_N       (BITS_N)
  ) u_uart_rx (
    .clk         (clk),
    .rst         (rst),
    .rx_in       (bus.uart_in),
    .data        (rx_data),
    .byte_valid  (rx_valid),
    .framing_err (rx_ferr)
  );

  // 8-bit view of the character for ASCII comparisons
  logic [7:0] ch;
  if (BITS_N >= 8) begin : g_ch_trunc
    assign ch = rx_data[7:0];
  end else begin : g_ch_pad
    assign ch = {{(8 - BITS_N){1'b0}}, rx_data};
  end

  parser_state_t     state_q, state_d;
  logic [16:0]       acc_q, acc_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [1:0]        key_idx_q, key_idx_d;
  logic              have_dig_q, have_dig_d;
  logic [15:0]       msg_type_q, msg_type_d;
  logic              msg_valid_q, msg_valid_d;
  logic              frame_error_q, frame_error_d;
  logic [BITS_N-1:0] rx_byte_q, rx_byte_d;

  logic              parse_err;
  logic              parse_emit;
  logic [LEN_W-1:0]  len_inc;
  logic              is_digit;
  // Wide enough that acc*10+digit can never wrap before the range check.
  logic [20:0]       acc_next;

  assign len_inc  = len_q + LEN_W'(1);
  assign is_digit = (ch >= ASCII_ZERO) && (ch <= ASCII_NINE);
  assign acc_next = ({4'd0, acc_q} * 21'd10) + {17'd0, ch[3:0]};

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= PS_IDLE;
      acc_q         <= '0;
      len_q         <= '0;
      key_idx_q     <= '0;
      have_dig_q    <= 1'b0;
      msg_type_q    <= '0;
      msg_valid_q   <= 1'b0;
      frame_error_q <= 1'b0;
      rx_byte_q     <= '0;
    end else begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      len_q         <= len_d;
      key_idx_q     <= key_idx_d;
      have_dig_q    <= have_dig_d;
      msg_type_q    <= msg_type_d;
      msg_valid_q   <= msg_valid_d;
      frame_error_q <= frame_error_d;
      rx_byte_q     <= rx_byte_d;
    end
  end

  // Next-state logic: one decision per received character
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    len_d      = len_q;
    key_idx_d  = key_idx_q;
    have_dig_d = have_dig_q;
    parse_err  = 1'b0;
    parse_emit = 1'b0;

    if (rx_ferr) begin
      // A corrupted character only matters while a frame is open.
      if (state_q != PS_IDLE) begin
        parse_err = 1'b1;
        state_d   = PS_IDLE;
      end
    end else if (rx_valid) begin
      if (ch == ASCII_LBRACE) begin
        // '{' always (re)starts a frame, even mid-frame, silently.
        state_d    = PS_KEY;
        acc_d      = '0;
        len_d      = LEN_W'(1);
        key_idx_d  = '0;
        have_dig_d = 1'b0;
      end else if (state_q != PS_IDLE) begin
        len_d = len_inc;
        case (state_q)
          PS_KEY: begin
            if (ch == key_char(key_idx_q)) begin
              if (key_idx_q == 2'd3) begin
                state_d    = PS_NUM;
                acc_d      = '0;
                have_dig_d = 1'b0;
              end else begin
                key_idx_d = key_idx_q + 2'd1;
              end
            end else if (ch != ASCII_SPACE) begin
              parse_err = 1'b1;
            end
          end
          PS_NUM: begin
            if (is_digit) begin
              if (acc_next > 21'd65535) begin
                parse_err = 1'b1;
              end else begin
                acc_d      = acc_next[16:0];
                have_dig_d = 1'b1;
              end
            end else if ((ch == ASCII_COMMA) && have_dig_q) begin
              state_d = PS_SKIP;
            end else if ((ch == ASCII_RBRACE) && have_dig_q) begin
              parse_emit = 1'b1;
            end else if (ch != ASCII_SPACE) begin
              // Spaces are padding around the number, e.g. ": 42 }".
              parse_err = 1'b1;
            end
          end
          PS_SKIP: begin
            if (ch == ASCII_RBRACE) parse_emit = 1'b1;
          end
          default: parse_err = 1'b1;
        endcase

        // Frame too long: the MAX_BYTES-th character is not a closing '}'.
        if (!parse_err && !parse_emit && (len_inc >= LEN_LIMIT)) begin
          parse_err = 1'b1;
        end
        if (parse_err || parse_emit) state_d = PS_IDLE;
      end
    end
  end

  // Output logic
  always_comb begin
    msg_valid_d   = parse_emit;
    frame_error_d = parse_err;
    msg_type_d    = parse_emit ? acc_q[15:0] : msg_type_q;
    rx_byte_d     = rx_valid ? rx_data : rx_byte_q;
  end

  assign bus.msg_type    = msg_type_q;
  assign bus.msg_valid   = msg_valid_q;
  assign bus.frame_error = frame_error_q;
  assign bus.rx_byte     = rx_byte_q;

endmodule
`default_nettype wire

// File: tb/tb_json_feedback_receiver.sv
`default_nettype none
// ============================================================================
// Module : tb_json_feedback_receiver
// Purpose: Directed self-checking bench for json_feedback_receiver.
// Rev    : 1.0  initial release
// ============================================================================
module tb_json_feedback_receiver;

  localparam int CPB       = 16;
  localparam int MAX_BYTES = 64;

  logic clk;
  logic rst;

  json_feedback_receiver_if #(.BITS_N(8)) bus ();

  json_feedback_receiver #(
    .CLKS_PER_BIT (CPB),
    .BITS_N       (8),
    .MAX_BYTES    (MAX_BYTES)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Pulse counters sampled away from the active edge
  int vld_cnt  = 0;
  int err_cnt  = 0;
  int both_cnt = 0;
  int v0 = 0;
  int e0 = 0;

  always @(negedge clk) begin
    if (bus.msg_valid) vld_cnt = vld_cnt + 1;
    if (bus.frame_error) err_cnt = err_cnt + 1;
    if (bus.msg_valid && bus.frame_error) both_cnt = both_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic mark();
    v0 = vld_cnt;
    e0 = err_cnt;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    bus.uart_in = 1'b0;
    idle(CPB);
    for (int i = 0; i < 8; i++) begin
      bus.uart_in = b[i];
      idle(CPB);
    end
    bus.uart_in = stop;
    idle(CPB);
    bus.uart_in = 1'b1;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
    idle(4);
  endtask

  initial begin
    bus.uart_in = 1'b1;
    rst = 1'b1;
    idle(5);
    check_eq("reset msg_type", 32'(bus.msg_type), 0);
    check_eq("reset msg_valid", 32'(bus.msg_valid), 0);
    check_eq("reset frame_error", 32'(bus.frame_error), 0);
    check_eq("reset rx_byte", 32'(bus.rx_byte), 0);
    rst = 1'b0;
    idle(2 * CPB);

    // Full frame with extra keys
    mark();
    send_str("{\"T\":1001,\"L\":0.5,\"R\":0.5}");
    check_eq("t1001 valid count", 32'(vld_cnt - v0), 1);
    check_eq("t1001 error count", 32'(err_cnt - e0), 0);
    check_eq("t1001 msg_type", 32'(bus.msg_type), 1001);
    check_eq("t1001 rx_byte", 32'(bus.rx_byte), 32'h7D);

    // Overflow
    mark();
    send_str("{\"T\":70000}");
    check_eq("ovf error count", 32'(err_cnt - e0), 1);
    check_eq("ovf valid count", 32'(vld_cnt - v0), 0);
    check_eq("ovf msg_type held", 32'(bus.msg_type), 1001);

    // Wrong key: error lands on 'X'
    mark();
    send_str("{\"X");
    check_eq("badkey error on X", 32'(err_cnt - e0), 1);
    send_str("\":5}");
    check_eq("badkey error total", 32'(err_cnt - e0), 1);
    check_eq("badkey valid count", 32'(vld_cnt - v0), 0);
    mark();
    send_str("{\"T\":3}");
    check_eq("t3 valid count", 32'(vld_cnt - v0), 1);
    check_eq("t3 msg_type", 32'(bus.msg_type), 3);

    // Whitespace tolerance, then missing number
    mark();
    send_str("{ \"T\" : 42 }");
    check_eq("ws valid count", 32'(vld_cnt - v0), 1);
    check_eq("ws msg_type", 32'(bus.msg_type), 42);
    check_eq("ws error count", 32'(err_cnt - e0), 0);
    mark();
    send_str("{\"T\":}");
    check_eq("empty error count", 32'(err_cnt - e0), 1);
    check_eq("empty valid count", 32'(vld_cnt - v0), 0);
    check_eq("empty msg_type held", 32'(bus.msg_type), 42);

    // Bad stop bit inside a frame
    mark();
    send_str("{\"T");
    send_byte(8'h22, 1'b0);
    idle(CPB);
    check_eq("stop0 error count", 32'(err_cnt - e0), 1);
    check_eq("stop0 byte dropped", 32'(bus.rx_byte), 32'h54);

    // Short glitch on an idle line
    mark();
    bus.uart_in = 1'b0;
    idle(5);
    bus.uart_in = 1'b1;
    idle(3 * CPB);
    check_eq("glitch rx_byte", 32'(bus.rx_byte), 32'h54);
    check_eq("glitch pulses", 32'((vld_cnt - v0) + (err_cnt - e0)), 0);
    mark();
    send_str("{\"T\":9}");
    check_eq("t9 msg_type", 32'(bus.msg_type), 9);
    check_eq("t9 valid count", 32'(vld_cnt - v0), 1);

    // Reset in the middle of the character '3' of 12345
    mark();
    send_str("{\"T\":12");
    bus.uart_in = 1'b0;       // start bit of '3' (0x33)
    idle(CPB);
    bus.uart_in = 1'b1;       // bit0
    idle(CPB);
    bus.uart_in = 1'b1;       // bit1
    idle(CPB);
    bus.uart_in = 1'b0;       // bit2
    idle(CPB / 2);
    rst = 1'b1;
    idle(3);
    bus.uart_in = 1'b1;
    rst = 1'b0;
    idle(2 * CPB);
    check_eq("midrst pulses", 32'((vld_cnt - v0) + (err_cnt - e0)), 0);
    check_eq("midrst msg_type", 32'(bus.msg_type), 0);
    check_eq("midrst rx_byte", 32'(bus.rx_byte), 0);
    send_str("{\"T\":7}");
    check_eq("t7 valid count", 32'(vld_cnt - v0), 1);
    check_eq("t7 error count", 32'(err_cnt - e0), 0);
    check_eq("t7 msg_type", 32'(bus.msg_type), 7);

    // Length limit: 63 characters open, 64th without '}' fails
    mark();
    send_str("{\"T\":1,");
    for (int i = 0; i < 56; i++) send_byte(8'h61, 1'b1);
    idle(4);
    check_eq("len63 error count", 32'(err_cnt - e0), 0);
    send_byte(8'h61, 1'b1);
    idle(4);
    check_eq("len64 error count", 32'(err_cnt - e0), 1);
    check_eq("len64 valid count", 32'(vld_cnt - v0), 0);
    check_eq("len64 msg_type held", 32'(bus.msg_type), 7);

    check_eq("valid and error overlap", 32'(both_cnt), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/json_feedback_receiver.md
JSON_FEEDBACK_RECEIVER -- requirements
Module: json_feedback_receiver

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, clock cycles per UART bit (50 MHz / 115200).
REQ-002 Parameter BITS_N, default 8, data bits per UART character.
REQ-003 Parameter MAX_BYTES, default 64, maximum characters in one frame, counted from '{' through '}' inclusive.
REQ-004 clk  input  1  system clock, 50 MHz; all logic SHALL be on its rising edge; one clock; reset is synchronous and active-high.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 uart_in  input  1  asynchronous UART line, idle high, 8N1, LSB first.
REQ-007 msg_type  output  16  value of the "T" key from the last good frame; holds between frames.
REQ-008 msg_valid  output  1  one-cycle pulse; msg_type updated in the same cycle.
REQ-009 frame_error  output  1  one-cycle pulse on any malformed or aborted frame.
REQ-010 rx_byte  output  BITS_N  last received character, debug only.

Function
REQ-011 uart_in SHALL pass through a 2-flop synchronizer before any use.
REQ-012 RX: falling edge while idle starts a bit timer; start bit resampled at CLKS_PER_BIT/2, and a high sample returns RX to idle with no byte.
REQ-013 Data bits SHALL be sampled every CLKS_PER_BIT cycles from mid-start; the stop bit is sampled the same way.
REQ-014 Stop bit high: byte_valid pulses 1 cycle after the stop sample. Stop bit low: byte dropped, frame_error pulses if a frame is open, RX returns to idle.
REQ-015 Parser states: IDLE, KEY, NUM, SKIP.
REQ-016 IDLE: wait for '{' (0x7B), then clear accumulator and length counter and go to KEY; all other bytes ignored.
REQ-017 KEY: match the sequence '"','T','"',':' exactly; whitespace (0x20) before a sequence character allowed; on full match go to NUM; any other byte SHALL give frame_error and IDLE.
REQ-018 NUM: digit '0'-'9' gives acc = acc*10 + digit in 17-bit arithmetic, and acc > 65535 SHALL give frame_error and IDLE.
REQ-019 NUM: ',' with at least one digit goes to SKIP; '}' with at least one digit emits the value; no digits or any other byte gives frame_error and IDLE.
REQ-020 SKIP: bytes ignored until '}', which emits the value.
REQ-021 Emit: msg_type <= acc[15:0], msg_valid pulses 1 cycle after the byte_valid of '}', then IDLE.
REQ-022 '{' received in KEY, NUM or SKIP SHALL restart the frame (go to KEY, counters cleared) without frame_error.
REQ-023 Length counter increments per byte in an open frame; reaching MAX_BYTES without '}' gives frame_error and IDLE.
REQ-024 msg_valid and frame_error SHALL never be asserted in the same cycle.

Reset
REQ-025 rst SHALL force RX idle, parser IDLE, msg_type=0, msg_valid=0, frame_error=0, rx_byte=0, synchronizer flops=1.
REQ-026 rst mid-byte or mid-frame SHALL discard the partial byte or frame with no pulse; the next '{' starts cleanly.

Structure
REQ-027 Shared package SHALL hold: ASCII constants ('{','}','"',':',',','T',' '), the parser state enum, and the default baud constant.
REQ-028 Byte reception SHALL be one sub-module, uart_rx (CLKS_PER_BIT, BITS_N; clk, rst, rx_in, data, byte_valid, framing_err); the parser stays in the top.

Verification
REQ-029 Send {"T":1001,"L":0.5,"R":0.5}: msg_valid exactly once, msg_type=1001, no frame_error.
REQ-030 Send {"T":70000}: frame_error once, no msg_valid, msg_type unchanged.
REQ-031 Send {"X":5}: frame_error on 'X', then {"T":3}: msg_type=3.
REQ-032 Send { "T" : 42 }: msg_type=42. Send {"T":}: frame_error.
REQ-033 Send a byte with the stop bit forced low inside a frame: frame_error, byte dropped. Send a 0.3-bit glitch low on an idle line: nothing received.
REQ-034 Assert rst at mid-digit of {"T":12345}, then send {"T":7}: only msg_type=7 reported. Send 64 bytes with no '}': frame_error on the 64th byte.
